// File: rtl/loeffler_dct_8.sv
// Microcoded 8-point Loeffler/islow forward DCT. It fetches eight signed samples
// and computes 16-bit Q7 coefficients through a scratchpad, writes them out, then halts.

module ice40_ebr #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] din,
  input  logic                  write_en,
  input  logic [addr_width-1:0] waddr,
  input  logic                  wclk,
  input  logic [addr_width-1:0] raddr,
  input  logic                  rclk,
  output logic [data_width-1:0] dout
);
  logic [data_width-1:0] mem [2**addr_width];

  always_ff @(posedge wclk) begin
    if (write_en) mem[waddr] <= din;
  end

  always_ff @(posedge rclk) begin
    dout <= mem[raddr];
  end
endmodule

module loeffler_dct_8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  fetch_data,
  output logic [2:0]  fetch_addr,
  output logic        fetch_clk,
  output logic [15:0] result_out,
  output logic [2:0]  result_addr,
  output logic        result_wren,
  output logic        result_clk
);
  typedef enum logic [2:0] {
    OP_HALT, OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_OUT_ADD, OP_OUT_SUB
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [4:0]        dst;
    logic [4:0]        src_a;
    logic [4:0]        src_b;
    logic [2:0]        idx;
    logic signed [9:0] coef;
  } uinst_t;

  localparam logic [5:0] HALT_PC = 6'd57;

  function automatic uinst_t ld(input logic [2:0] k, input logic [4:0] d);
    return '{op: OP_LOAD, dst: d, src_a: 5'd0, src_b: 5'd0, idx: k, coef: 10'sd0};
  endfunction

  function automatic uinst_t alu(input op_t kind, input logic [4:0] d, input logic [4:0] a,
                                 input logic [4:0] b);
    return '{op: kind, dst: d, src_a: a, src_b: b, idx: 3'd0, coef: 10'sd0};
  endfunction

  function automatic uinst_t mul(input logic [4:0] d, input logic [4:0] a,
                                 input logic signed [9:0] c);
    return '{op: OP_MUL, dst: d, src_a: a, src_b: 5'd0, idx: 3'd0, coef: c};
  endfunction

  function automatic uinst_t put(input op_t kind, input logic [2:0] k, input logic [4:0] a,
                                 input logic [4:0] b);
    return '{op: kind, dst: 5'd0, src_a: a, src_b: b, idx: k, coef: 10'sd0};
  endfunction

  // Stage-1 results stay at 0..7; 8..23 are reused temporaries. Any consumer sits
  // at least two slots after its producer because of the registered scratchpad read.
  function automatic uinst_t ucode(input logic [5:0] a);
    case (a)
      6'd0:  return ld(3'd0, 5'd8);
      6'd1:  return ld(3'd7, 5'd15);
      6'd2:  return ld(3'd1, 5'd9);
      6'd3:  return ld(3'd6, 5'd14);
      6'd4:  return ld(3'd2, 5'd10);
      6'd5:  return ld(3'd5, 5'd13);
      6'd6:  return ld(3'd3, 5'd11);
      6'd7:  return ld(3'd4, 5'd12);
      6'd8:  return alu(OP_ADD, 5'd0, 5'd8, 5'd15);
      6'd9:  return alu(OP_SUB, 5'd7, 5'd8, 5'd15);
      6'd10: return alu(OP_ADD, 5'd1, 5'd9, 5'd14);
      6'd11: return alu(OP_SUB, 5'd6, 5'd9, 5'd14);
      6'd12: return alu(OP_ADD, 5'd2, 5'd10, 5'd13);
      6'd13: return alu(OP_SUB, 5'd5, 5'd10, 5'd13);
      6'd14: return alu(OP_ADD, 5'd3, 5'd11, 5'd12);
      6'd15: return alu(OP_SUB, 5'd4, 5'd11, 5'd12);
      6'd16: return alu(OP_ADD, 5'd16, 5'd0, 5'd3);
      6'd17: return alu(OP_ADD, 5'd17, 5'd1, 5'd2);
      6'd18: return alu(OP_SUB, 5'd18, 5'd0, 5'd3);
      6'd19: return alu(OP_SUB, 5'd19, 5'd1, 5'd2);
      6'd20: return put(OP_OUT_ADD, 3'd0, 5'd16, 5'd17);
      6'd21: return put(OP_OUT_SUB, 3'd4, 5'd16, 5'd17);
      6'd22: return alu(OP_ADD, 5'd20, 5'd19, 5'd18);
      6'd23: return mul(5'd21, 5'd18, 10'sd98);
      6'd24: return mul(5'd22, 5'd20, 10'sd69);
      6'd25: return mul(5'd23, 5'd19, -10'sd237);
      6'd26: return put(OP_OUT_ADD, 3'd2, 5'd22, 5'd21);
      6'd27: return put(OP_OUT_ADD, 3'd6, 5'd22, 5'd23);
      6'd28: return alu(OP_ADD, 5'd8, 5'd4, 5'd7);
      6'd29: return alu(OP_ADD, 5'd9, 5'd5, 5'd6);
      6'd30: return alu(OP_ADD, 5'd10, 5'd4, 5'd6);
      6'd31: return alu(OP_ADD, 5'd11, 5'd5, 5'd7);
      6'd32: return mul(5'd12, 5'd4, 10'sd38);
      6'd33: return alu(OP_ADD, 5'd13, 5'd10, 5'd11);
      6'd34: return mul(5'd14, 5'd5, 10'sd263);
      6'd35: return mul(5'd15, 5'd13, 10'sd151);
      6'd36: return mul(5'd16, 5'd6, 10'sd393);
      6'd37: return mul(5'd17, 5'd7, 10'sd192);
      6'd38: return mul(5'd18, 5'd8, -10'sd115);
      6'd39: return mul(5'd19, 5'd9, -10'sd328);
      6'd40: return mul(5'd20, 5'd10, -10'sd251);
      6'd41: return mul(5'd21, 5'd11, -10'sd50);
      6'd42: return alu(OP_ADD, 5'd22, 5'd20, 5'd15);
      6'd43: return alu(OP_ADD, 5'd23, 5'd21, 5'd15);
      6'd44: return alu(OP_ADD, 5'd8, 5'd12, 5'd18);
      6'd45: return alu(OP_ADD, 5'd9, 5'd14, 5'd19);
      6'd46: return alu(OP_ADD, 5'd10, 5'd16, 5'd19);
      6'd47: return alu(OP_ADD, 5'd11, 5'd17, 5'd18);
      6'd48: return put(OP_OUT_ADD, 3'd7, 5'd8, 5'd22);
      6'd49: return put(OP_OUT_ADD, 3'd5, 5'd9, 5'd23);
      6'd50: return put(OP_OUT_ADD, 3'd3, 5'd10, 5'd22);
      6'd51: return put(OP_OUT_ADD, 3'd1, 5'd11, 5'd23);
      // Remaining slots up to HALT only touch a dead temporary.
      default: return (a < HALT_PC) ? alu(OP_ADD, 5'd13, 5'd13, 5'd13)
                                    : alu(OP_HALT, 5'd0, 5'd0, 5'd0);
    endcase
  endfunction

  logic [5:0]        ucode_pc, pc_adv, pc_next;
  uinst_t            fetched;
  op_t               inst_op;
  logic [4:0]        inst_dst;
  logic [2:0]        inst_idx;
  logic signed [9:0] inst_coef;
  logic [15:0]       opnd_a, opnd_b, sum, diff, scaled, wr_data;
  logic signed [22:0] product;
  logic              wr_en;

  // Operand reads and source fetches are issued for the next slot, so the
  // instruction at ucode_pc finds its operands registered and retires in-slot.
  always_comb begin
    pc_adv  = (ucode_pc == HALT_PC) ? HALT_PC : ucode_pc + 6'd1;
    pc_next = reset ? '0 : pc_adv;
    fetched = ucode(pc_next);
  end

  always_ff @(posedge clock) begin
    if (reset) ucode_pc <= '0;
    else       ucode_pc <= pc_adv;
    inst_op   <= fetched.op;
    inst_dst  <= fetched.dst;
    inst_idx  <= fetched.idx;
    inst_coef <= fetched.coef;
  end

  assign fetch_addr = fetched.idx;
  assign fetch_clk  = clock;
  assign result_clk = clock;

  // Two mirrored copies give the two read ports an ALU op needs each slot.
  ice40_ebr #(.addr_width(5), .data_width(16)) scratchpad (
    .din(wr_data), .write_en(wr_en), .waddr(inst_dst), .wclk(clock),
    .raddr(fetched.src_a), .rclk(clock), .dout(opnd_a)
  );

  ice40_ebr #(.addr_width(5), .data_width(16)) scratchpad_b (
    .din(wr_data), .write_en(wr_en), .waddr(inst_dst), .wclk(clock),
    .raddr(fetched.src_b), .rclk(clock), .dout(opnd_b)
  );

  always_comb begin
    sum     = opnd_a + opnd_b;
    diff    = opnd_a - opnd_b;
    product = 23'(signed'(opnd_a)) * 23'(inst_coef);
    scaled  = 16'(product >>> 7);
  end

  always_comb begin
    wr_en       = 1'b0;
    wr_data     = '0;
    result_wren = 1'b0;
    result_addr = '0;
    result_out  = '0;
    if (!reset) begin
      case (inst_op)
        OP_LOAD: begin wr_en = 1'b1; wr_data = {{8{fetch_data[7]}}, fetch_data}; end
        OP_ADD:  begin wr_en = 1'b1; wr_data = sum;    end
        OP_SUB:  begin wr_en = 1'b1; wr_data = diff;   end
        OP_MUL:  begin wr_en = 1'b1; wr_data = scaled; end
        OP_OUT_ADD: begin result_wren = 1'b1; result_addr = inst_idx; result_out = sum;  end
        OP_OUT_SUB: begin result_wren = 1'b1; result_addr = inst_idx; result_out = diff; end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_loeffler_dct_8.sv
// Bench for loeffler_dct_8: source/destination RAM models, a formula-level DCT
// reference, and scenario tasks for reset, fixed patterns, random data and aborts.

module tb_loeffler_dct_8;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fetch_data = '0;
  logic [2:0]  fetch_addr;
  logic        fetch_clk;
  logic [15:0] result_out;
  logic [2:0]  result_addr;
  logic        result_wren;
  logic        result_clk;

  loeffler_dct_8 dut (
    .clock(clock), .reset(reset), .fetch_data(fetch_data), .fetch_addr(fetch_addr),
    .fetch_clk(fetch_clk), .result_out(result_out), .result_addr(result_addr),
    .result_wren(result_wren), .result_clk(result_clk)
  );

  always #5 clock = ~clock;

  logic signed [7:0] src_mem [8];
  logic [15:0]       dst_mem [8];
  int                wr_cnt [8];
  int                total_wr = 0;
  int                halt_wr = 0;
  int                base_cnt [8];
  int                base_total = 0;
  shortint           exp_t [8];
  shortint           exp_x [8];
  int                checks = 0;
  int                errors = 0;

  always @(posedge fetch_clk) fetch_data <= src_mem[fetch_addr];

  always @(posedge result_clk) begin
    if (result_wren === 1'b1) begin
      dst_mem[result_addr] <= result_out;
      wr_cnt[result_addr]  <= wr_cnt[result_addr] + 1;
      total_wr             <= total_wr + 1;
      if (dut.ucode_pc == 6'd57) halt_wr <= halt_wr + 1;
    end
  end

  function automatic shortint mc(input shortint v, input int c);
    return shortint'((int'(v) * c) >>> 7);
  endfunction

  task automatic compute_expected();
    shortint x [8];
    shortint t [8];
    shortint u0, u1, u2, u3, z, z1, z2, z3, z4, z5, q1, q2, q3, q4;
    for (int i = 0; i < 8; i++) x[i] = shortint'(src_mem[i]);
    for (int i = 0; i < 4; i++) begin
      t[i]     = x[i] + x[7-i];
      t[7-i]   = x[i] - x[7-i];
    end
    u0 = t[0] + t[3]; u1 = t[1] + t[2]; u2 = t[1] - t[2]; u3 = t[0] - t[3];
    z  = mc(u2 + u3, 69);
    exp_x[0] = u0 + u1;
    exp_x[4] = u0 - u1;
    exp_x[2] = z + mc(u3, 98);
    exp_x[6] = z + mc(u2, -237);
    z1 = t[4] + t[7]; z2 = t[5] + t[6]; z3 = t[4] + t[6]; z4 = t[5] + t[7];
    z5 = mc(z3 + z4, 151);
    q1 = mc(z1, -115); q2 = mc(z2, -328);
    q3 = mc(z3, -251) + z5; q4 = mc(z4, -50) + z5;
    exp_x[7] = mc(t[4], 38) + q1 + q3;
    exp_x[5] = mc(t[5], 263) + q2 + q4;
    exp_x[3] = mc(t[6], 393) + q2 + q3;
    exp_x[1] = mc(t[7], 192) + q1 + q4;
    for (int i = 0; i < 8; i++) exp_t[i] = t[i];
  endtask

  task automatic snapshot();
    base_total = total_wr;
    for (int i = 0; i < 8; i++) base_cnt[i] = wr_cnt[i];
  endtask

  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (dut.ucode_pc !== 6'd57 && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  task automatic execute_run(output int cycles);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    snapshot();
    reset = 1'b0;
    wait_halt(cycles);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) src_mem[i] = 8'($urandom);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (dut.ucode_pc !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", dut.ucode_pc); end
    checks++; if (fetch_addr !== 3'd0) begin errors++; $display("FAIL reset_fetch_addr: got %0d expected 0", fetch_addr); end
    checks++; if (result_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", result_wren); end
    checks++; if (result_addr !== 3'd0) begin errors++; $display("FAIL reset_result_addr: got %0d expected 0", result_addr); end
    checks++; if (result_out !== 16'h0000) begin errors++; $display("FAIL reset_result_out: got %h expected 0000", result_out); end
    checks++; if (fetch_clk !== clock || result_clk !== clock) begin
      errors++; $display("FAIL ram_clocks: got fetch_clk=%b result_clk=%b expected %b", fetch_clk, result_clk, clock);
    end
  endtask

  task automatic test_ramp();
    logic [15:0] ramp_t [8] = '{16'h0009, 16'h0009, 16'h0009, 16'h0009,
                                16'hFFFF, 16'hFFFD, 16'hFFFB, 16'hFFF9};
    shortint     ramp_x [8] = '{36, -20, 0, -4, 0, -3, 0, -2};
    int cyc;
    for (int i = 0; i < 8; i++) src_mem[i] = 8'(i + 1);
    execute_run(cyc);
    checks++; if (cyc != 57) begin errors++; $display("FAIL ramp_halt_cycles: got %0d expected 57", cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.scratchpad.mem[i] !== ramp_t[i]) begin
        errors++; $display("FAIL ramp_stage1[%0d]: got %h expected %h", i, dut.scratchpad.mem[i], ramp_t[i]);
      end
      checks++;
      if (dst_mem[i] !== 16'(ramp_x[i]) || wr_cnt[i] - base_cnt[i] != 1) begin
        errors++; $display("FAIL ramp_X[%0d]: got %h (%0d writes) expected %h (1 write)", i, dst_mem[i],
                           wr_cnt[i] - base_cnt[i], 16'(ramp_x[i]));
      end
    end
  endtask

  task automatic test_constant_inputs();
    logic signed [7:0] levels [2] = '{8'sd0, -8'sd128};
    int cyc;
    foreach (levels[p]) begin
      for (int i = 0; i < 8; i++) src_mem[i] = levels[p];
      execute_run(cyc);
      checks++; if (cyc != 57) begin errors++; $display("FAIL const%0d_halt_cycles: got %0d expected 57", p, cyc); end
      for (int k = 0; k < 8; k++) begin
        logic [15:0] want;
        want = (k == 0) ? 16'(int'(levels[p]) * 8) : 16'h0000;
        checks++;
        if (dst_mem[k] !== want || wr_cnt[k] - base_cnt[k] != 1) begin
          errors++; $display("FAIL const%0d_X[%0d]: got %h (%0d writes) expected %h (1 write)", p, k, dst_mem[k],
                             wr_cnt[k] - base_cnt[k], want);
        end
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++)
        src_mem[i] = (n == 0) ? ((i % 2 == 0) ? 8'sd127 : -8'sd128) : 8'($urandom);
      compute_expected();
      execute_run(cyc);
      checks++; if (cyc != 57) begin errors++; $display("FAIL rand%0d_halt_cycles: got %0d expected 57", n, cyc); end
      checks++; if (total_wr - base_total != 8) begin
        errors++; $display("FAIL rand%0d_write_count: got %0d expected 8", n, total_wr - base_total);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (dut.scratchpad.mem[k] !== 16'(exp_t[k])) begin
          errors++; $display("FAIL rand%0d_stage1[%0d]: got %h expected %h", n, k, dut.scratchpad.mem[k], 16'(exp_t[k]));
        end
        checks++;
        if (dst_mem[k] !== 16'(exp_x[k]) || wr_cnt[k] - base_cnt[k] != 1) begin
          errors++; $display("FAIL rand%0d_X[%0d]: got %h (%0d writes) expected %h (1 write)", n, k, dst_mem[k],
                             wr_cnt[k] - base_cnt[k], 16'(exp_x[k]));
        end
      end
    end
  endtask

  task automatic test_halt_freeze();
    int wren_seen = 0;
    snapshot();
    repeat (12) begin
      @(posedge clock); #1;
      if (result_wren !== 1'b0) wren_seen++;
    end
    checks++; if (dut.ucode_pc !== 6'd57) begin errors++; $display("FAIL halt_pc_hold: got %0d expected 57", dut.ucode_pc); end
    checks++; if (wren_seen != 0 || total_wr != base_total) begin
      errors++; $display("FAIL halt_no_writes: got %0d strobes, %0d writes expected 0", wren_seen, total_wr - base_total);
    end
    checks++; if (halt_wr != 0) begin errors++; $display("FAIL writes_in_halt: got %0d expected 0", halt_wr); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut.scratchpad.mem[k] !== 16'(exp_t[k])) begin
        errors++; $display("FAIL halt_frozen_stage1[%0d]: got %h expected %h", k, dut.scratchpad.mem[k], 16'(exp_t[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 8; i++) src_mem[i] = 8'($urandom);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc = 0;
    while (dut.ucode_pc !== 6'd30 && cyc < 100) begin @(posedge clock); #1; cyc++; end
    checks++; if (cyc != 30) begin errors++; $display("FAIL abort_reach_pc30: got %0d cycles expected 30", cyc); end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) src_mem[i] = src_mem[i] ^ 8'h5A;
    compute_expected();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (dut.ucode_pc !== 6'd0 || result_wren !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: got pc=%0d wren=%b expected pc=0 wren=0", dut.ucode_pc, result_wren);
    end
    snapshot();
    reset = 1'b0;
    wait_halt(cyc);
    checks++; if (cyc != 57) begin errors++; $display("FAIL abort_halt_cycles: got %0d expected 57", cyc); end
    checks++; if (total_wr - base_total != 8) begin
      errors++; $display("FAIL abort_write_count: got %0d expected 8", total_wr - base_total);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut.scratchpad.mem[k] !== 16'(exp_t[k])) begin
        errors++; $display("FAIL abort_stage1[%0d]: got %h expected %h", k, dut.scratchpad.mem[k], 16'(exp_t[k]));
      end
      checks++;
      if (dst_mem[k] !== 16'(exp_x[k]) || wr_cnt[k] - base_cnt[k] != 1) begin
        errors++; $display("FAIL abort_X[%0d]: got %h (%0d writes) expected %h (1 write)", k, dst_mem[k],
                           wr_cnt[k] - base_cnt[k], 16'(exp_x[k]));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_constant_inputs();
    test_random();
    test_halt_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
